mdl_xxx_bram_stream_out: RTL and testbench
==========================================

// Module: mdl_xxx_bram_stream_out
// PURPOSE
//  Write-back counterpart of the AXI-Stream-to-BRAM loader. Reads PRM_COEFFS
//  coefficients from the dual-port coefficient BRAM, two per cycle (port A at
//  even address, port B at address+1). Packs each pair into one 64-bit
//  AXI-Stream master beat toward the DMA. In NTT mode, maps [0,Q) back to the
//  signed centred form before packing.
// PARAMETERS
//  PRM_DAXI    64     stream data width; must equal 2*PRM_DRAM
//  PRM_ADDR    12     BRAM address width
//  PRM_DRAM    32     BRAM word / coefficient width
//  PRM_COEFFS  4096   coefficients per transfer; even, <= 2**PRM_ADDR
//  D1          28     bit width of Q1 = 134250497
//  D2          30     bit width of Q2 = 536903681
// PORTS
//  iSYS_CLK    in   1         single clock, all logic on rising edge
//  iSYS_RST    in   1         synchronous reset, active-high
//  iFSM_START  in   1         one-cycle start pulse
//  oFSM_DONE   out  1         one-cycle pulse after the last beat is accepted
//  iCTL_BUT    in   2         00 = PWM (raw), 01/10 = NTT (centre conversion)
//  iCTL_Q      in   2         00 = Q1, otherwise Q2
//  oB1_enA     out  1         BRAM port A read enable
//  oB1_addrA   out  PRM_ADDR  BRAM port A address (even)
//  iB1_doutA   in   PRM_DRAM  BRAM port A read data, 1-cycle latency
//  oB1_enB     out  1         BRAM port B read enable
//  oB1_addrB   out  PRM_ADDR  BRAM port B address (= addrA + 1)
//  iB1_doutB   in   PRM_DRAM  BRAM port B read data, 1-cycle latency
//  oMs_Tvalid  out  1         stream beat valid
//  oMs_Tdata   out  PRM_DAXI  {coef[addr+1], coef[addr]}; low half = port A
//  oMs_Tlast   out  1         high on the final beat (beat PRM_COEFFS/2-1)
//  iMs_Tready  in   1         downstream ready
// BEHAVIOUR
//  Reset values: all outputs 0. FSM = IDLE, counters and FIFO empty.
//  Reset mid-transfer aborts immediately. In-flight and buffered data are
//  discarded. No DONE is issued.
//  FSM states: IDLE -> RUN on iFSM_START.
//   RUN -> DRAIN after the read at address PRM_COEFFS-2 is issued.
//   DRAIN -> DONE when the last beat handshakes.
//   DONE -> IDLE after one cycle; oFSM_DONE = 1 in DONE only.
//  iFSM_START outside IDLE is ignored.
//  iCTL_BUT and iCTL_Q are latched on the accepted start and held for the transfer.
//  Read issue: in RUN, a read pair issues when (fifo_cnt + inflight - pop) < 2,
//   where pop = oMs_Tvalid & iMs_Tready.
//   On issue: enA = enB = 1, addrA = rd_cnt, addrB = rd_cnt + 1, rd_cnt += 2.
//   rd_cnt is PRM_ADDR+1 bits wide and resets to 0 on each accepted start.
//  Returned data (cycle after issue): convert, then push into a 2-entry FIFO.
//   oMs_Tvalid/Tdata/Tlast are registered from the FIFO head.
//  Conversion: NTT: c > (Q-1)/2 -> c - Q (two's complement, PRM_DRAM bits),
//   else c. PWM: pass-through. Q is zero-extended to PRM_DRAM bits.
//  Each beat's Tlast is tagged at issue time and travels with its data.
//  AXI rules: once oMs_Tvalid = 1, Tvalid, Tdata and Tlast stay stable until
//   iMs_Tready = 1.
//   iMs_Tready low for any length: reads stall, no beat is lost or duplicated.
//   Tvalid never depends combinationally on Tready.
//  Latency: start at edge 0 -> first enA at cycle 1 -> data into FIFO at
//   cycle 2 -> oMs_Tvalid = 1 at cycle 3.
//  Throughput: with Tready held high, one beat per cycle.
//   A 4096-coefficient transfer ends its last beat at cycle 2050.
//   oFSM_DONE pulses at cycle 2051.
//  Boundaries: c = (Q-1)/2 stays positive; c = (Q+1)/2 becomes negative.
//   c = 0 maps to 0. The FIFO never exceeds 2 entries; an overflow is an
//   assertion failure.
// TESTING
//  T1 PWM, Q1, Tready=1, BRAM[i]=i: 2048 beats; beat k = {2k+1, 2k};
//   Tlast on beat 2047 only; DONE at cycle 2051.
//  T2 NTT, Q1: BRAM[0]=0, [1]=67125248, [2]=67125249, [3]=134250496
//   -> beat0 = {67125248, 0}; beat1 = {32'hFFFFFFFF, -67125248}.
//  T3 NTT, Q2: BRAM[0]=536903680 -> low half 32'hFFFFFFFF.
//   BRAM[1]=268451840 -> unchanged.
//  T4 Random Tready (30% high), plus a 50-cycle Tready-low window:
//   data and Tlast are stable while stalled; scoreboard matches all 2048 beats.
//  T5 Second iFSM_START mid-transfer is ignored.
//   Back-to-back transfers (start one cycle after DONE) are each complete.
//  T6 iSYS_RST=1 at beat 100: all outputs are 0 next cycle, no DONE.
//   A new start then yields a full correct transfer.

Source files
------------

// File: rtl/mdl_xxx_bram_stream_out.sv
// Streams coefficient pairs from a dual-port BRAM as 64-bit AXI-Stream beats,
// optionally folding NTT residues in [0,Q) back to signed centred form.
module mdl_xxx_bram_stream_out #(
  parameter int PRM_DAXI   = 64,
  parameter int PRM_ADDR   = 12,
  parameter int PRM_DRAM   = 32,
  parameter int PRM_COEFFS = 4096,
  parameter int D1         = 28,
  parameter int D2         = 30
) (
  input  logic                iSYS_CLK,
  input  logic                iSYS_RST,
  input  logic                iFSM_START,
  output logic                oFSM_DONE,
  input  logic [1:0]          iCTL_BUT,
  input  logic [1:0]          iCTL_Q,
  output logic                oB1_enA,
  output logic [PRM_ADDR-1:0] oB1_addrA,
  input  logic [PRM_DRAM-1:0] iB1_doutA,
  output logic                oB1_enB,
  output logic [PRM_ADDR-1:0] oB1_addrB,
  input  logic [PRM_DRAM-1:0] iB1_doutB,
  output logic                oMs_Tvalid,
  output logic [PRM_DAXI-1:0] oMs_Tdata,
  output logic                oMs_Tlast,
  input  logic                iMs_Tready
);

  localparam logic [D1-1:0]       Q1_N      = D1'(134250497);
  localparam logic [D2-1:0]       Q2_N      = D2'(536903681);
  localparam logic [PRM_DRAM-1:0] Q1        = PRM_DRAM'(Q1_N);
  localparam logic [PRM_DRAM-1:0] Q2        = PRM_DRAM'(Q2_N);
  localparam logic [PRM_DRAM-1:0] ONE       = PRM_DRAM'(1);
  localparam logic [PRM_ADDR:0]   LAST_ADDR = (PRM_ADDR+1)'(PRM_COEFFS - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [PRM_ADDR:0]     rd_cnt;
  logic                  inflight, inflight_last;
  logic                  ntt_mode, q2_sel;
  logic [PRM_DAXI-1:0]   fifo_data [2];
  logic                  fifo_last [2];
  logic                  fifo_wp, fifo_rp;
  logic [1:0]            fifo_cnt;
  logic                  fifo_pop, push, issue, issue_last, start_ok;
  logic [2:0]            occupancy;
  logic [PRM_DRAM-1:0]   q_val;

  // Values above (Q-1)/2 represent negatives; Q is odd so (Q-1)>>1 is exact.
  function automatic logic [PRM_DRAM-1:0] centre(input logic [PRM_DRAM-1:0] c,
                                                 input logic ntt,
                                                 input logic [PRM_DRAM-1:0] q);
    if (ntt && (c > ((q - ONE) >> 1))) return c - q;
    else                               return c;
  endfunction

  assign q_val    = q2_sel ? Q2 : Q1;
  assign push     = inflight;
  assign start_ok = (state == S_IDLE) && iFSM_START;
  // The head moves into the output register whenever that register is free.
  assign fifo_pop  = (fifo_cnt != 2'd0) && (!oMs_Tvalid || iMs_Tready);
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, fifo_pop};
  assign issue      = (state == S_RUN) && (occupancy < 3'd2);
  assign issue_last = issue && (rd_cnt == LAST_ADDR);

  assign oB1_enA   = issue;
  assign oB1_enB   = issue;
  assign oB1_addrA = issue ? rd_cnt[PRM_ADDR-1:0] : '0;
  assign oB1_addrB = issue ? (rd_cnt[PRM_ADDR-1:0] + PRM_ADDR'(1)) : '0;

  // Next-state logic for the transfer sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (iFSM_START) state_nxt = S_RUN; else state_nxt = S_IDLE;
      S_RUN:   if (issue_last) state_nxt = S_DRAIN; else state_nxt = S_RUN;
      S_DRAIN: if (oMs_Tvalid && iMs_Tready && oMs_Tlast) state_nxt = S_DONE;
               else state_nxt = S_DRAIN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, read counter, mode latch and in-flight tracking.
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      state         <= S_IDLE;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      ntt_mode      <= 1'b0;
      q2_sel        <= 1'b0;
      oFSM_DONE     <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= issue_last;
      oFSM_DONE     <= (state_nxt == S_DONE);
      if (start_ok) begin
        rd_cnt   <= '0;
        ntt_mode <= (iCTL_BUT == 2'b01) || (iCTL_BUT == 2'b10);
        q2_sel   <= (iCTL_Q != 2'b00);
      end else if (issue) begin
        rd_cnt   <= rd_cnt + (PRM_ADDR+1)'(2);
      end else begin
        rd_cnt   <= rd_cnt;
      end
    end
  end

  // FIFO storage; contents are qualified by fifo_cnt so need no reset.
  always_ff @(posedge iSYS_CLK) begin
    if (push) begin
      fifo_data[fifo_wp] <= {centre(iB1_doutB, ntt_mode, q_val),
                             centre(iB1_doutA, ntt_mode, q_val)};
      fifo_last[fifo_wp] <= inflight_last;
    end
  end

  // FIFO pointers/count and the registered stream output stage.
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      fifo_wp    <= 1'b0;
      fifo_rp    <= 1'b0;
      fifo_cnt   <= 2'd0;
      oMs_Tvalid <= 1'b0;
      oMs_Tdata  <= '0;
      oMs_Tlast  <= 1'b0;
    end else begin
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, fifo_pop};
      if (push) fifo_wp <= ~fifo_wp;
      if (fifo_pop) begin
        fifo_rp    <= ~fifo_rp;
        oMs_Tvalid <= 1'b1;
        oMs_Tdata  <= fifo_data[fifo_rp];
        oMs_Tlast  <= fifo_last[fifo_rp];
      end else if (iMs_Tready) begin
        oMs_Tvalid <= 1'b0;
      end
    end
  end

  fifo_no_overflow: assert property (@(posedge iSYS_CLK) disable iff (iSYS_RST)
    !(push && !fifo_pop && (fifo_cnt == 2'd2)));

endmodule

// File: tb/tb_mdl_xxx_bram_stream_out.sv
// Scoreboard bench for mdl_xxx_bram_stream_out: BRAM model, Tready patterns,
// restart/abort scenarios.
module tb_mdl_xxx_bram_stream_out;

  localparam int NC    = 4096;
  localparam int NB    = NC / 2;
  localparam longint Q1V = 134250497;
  localparam longint Q2V = 536903681;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [1:0]  ctl_but = 2'b00;
  logic [1:0]  ctl_q = 2'b00;
  logic        en_a, en_b;
  logic [11:0] addr_a, addr_b;
  logic [31:0] dout_a, dout_b;
  logic        tvalid, tlast;
  logic [63:0] tdata;
  logic        tready = 1'b1;

  logic [31:0] mem [0:NC-1];
  logic [64:0] exp_q [$];
  logic [63:0] obs_beat [0:1];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mdl_xxx_bram_stream_out dut (
    .iSYS_CLK(clk), .iSYS_RST(rst), .iFSM_START(start), .oFSM_DONE(done),
    .iCTL_BUT(ctl_but), .iCTL_Q(ctl_q),
    .oB1_enA(en_a), .oB1_addrA(addr_a), .iB1_doutA(dout_a),
    .oB1_enB(en_b), .oB1_addrB(addr_b), .iB1_doutB(dout_b),
    .oMs_Tvalid(tvalid), .oMs_Tdata(tdata), .oMs_Tlast(tlast), .iMs_Tready(tready)
  );

  always_ff @(posedge clk) begin
    if (en_a) dout_a <= mem[addr_a];
    if (en_b) dout_b <= mem[addr_b];
  end

  function automatic logic [31:0] conv(input logic [31:0] c, input logic ntt, input logic q2);
    longint cv;
    longint qv;
    cv = c;
    qv = q2 ? Q2V : Q1V;
    if (ntt && (cv > (qv - 1) / 2)) return 32'(cv - qv);
    else                            return c;
  endfunction

  // tmode 0: Tready high; 1: ~30% random plus a 50-cycle low window
  task automatic run_transfer(input logic [1:0] but, input logic [1:0] q, input int tmode,
                              input int extra_start, input int abort_beat, input int exp_done);
    logic        ntt, q2, done_seen, aborted, prev_stall, prev_last;
    logic [63:0] prev_data;
    logic [64:0] e;
    int          cyc, beats, first_valid;
    ntt = (but == 2'b01) || (but == 2'b10);
    q2  = (q != 2'b00);
    exp_q.delete();
    for (int k = 0; k < NB; k++)
      exp_q.push_back({(k == NB - 1), conv(mem[2*k+1], ntt, q2), conv(mem[2*k], ntt, q2)});
    @(negedge clk);
    ctl_but = but; ctl_q = q; start = 1'b1;
    cyc = -1; beats = 0; first_valid = -1;
    done_seen = 1'b0; aborted = 1'b0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    while (!done_seen && !aborted && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start   = (cyc == extra_start);
      ctl_but = ~but;
      ctl_q   = ~q;
      if (tvalid && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        tests++;
        if (!tvalid || tdata !== prev_data || tlast !== prev_last) begin
          fails++;
          $display("FAIL stall_stable cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   cyc, tvalid, tdata, tlast, prev_data, prev_last);
        end
      end
      if (en_a) begin
        tests++;
        if (!en_b || addr_b !== addr_a + 12'd1 || addr_a[0] !== 1'b0) begin
          fails++;
          $display("FAIL addr_pair got enB=%b A=%0d B=%0d want enB=1 B=A+1, A even",
                   en_b, addr_a, addr_b);
        end
      end
      if (done) begin
        done_seen = 1'b1;
        tests++;
        if (exp_q.size() != 0 || (exp_done >= 0 && cyc != exp_done)) begin
          fails++;
          $display("FAIL done_timing got cyc=%0d left=%0d want cyc=%0d left=0",
                   cyc, exp_q.size(), exp_done);
        end
      end
      if (abort_beat >= 0 && beats == abort_beat) begin
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (tvalid !== 1'b0 || tdata !== 64'd0 || tlast !== 1'b0 || done !== 1'b0 ||
            en_a !== 1'b0 || en_b !== 1'b0 || addr_a !== 12'd0 || addr_b !== 12'd0) begin
          fails++;
          $display("FAIL abort_outputs got v=%b d=%h l=%b done=%b enA=%b enB=%b want all 0",
                   tvalid, tdata, tlast, done, en_a, en_b);
        end
        rst = 1'b0;
        aborted = 1'b1;
        exp_q.delete();
      end else begin
        if (tmode == 0)                   tready = 1'b1;
        else if (cyc >= 500 && cyc < 550) tready = 1'b0;
        else                              tready = ($urandom_range(0, 99) < 30);
        if (tvalid && tready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL extra_beat got d=%h want no beat", tdata);
          end else begin
            e = exp_q.pop_front();
            if (tdata !== e[63:0] || tlast !== e[64]) begin
              fails++;
              $display("FAIL beat%0d got d=%h l=%b want d=%h l=%b",
                       beats, tdata, tlast, e[63:0], e[64]);
            end
          end
          if (beats < 2) obs_beat[beats] = tdata;
          beats++;
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
      end
    end
    start = 1'b0;
    if (!done_seen && !aborted) begin
      tests++; fails++;
      $display("FAIL timeout got beats=%0d want done", beats);
    end
    if (exp_done >= 0) begin
      tests++;
      if (first_valid != 3) begin
        fails++;
        $display("FAIL first_valid got cyc=%0d want 3", first_valid);
      end
    end
  endtask

  task automatic check_quiet(input string name, input int ncyc);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done || tvalid || en_a) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL %s got activity (done/valid/enA) want idle", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (tvalid !== 1'b0 || tdata !== 64'd0 || tlast !== 1'b0 || done !== 1'b0 ||
        en_a !== 1'b0 || en_b !== 1'b0 || addr_a !== 12'd0 || addr_b !== 12'd0) begin
      fails++;
      $display("FAIL reset_outputs got v=%b d=%h l=%b done=%b enA=%b want all 0",
               tvalid, tdata, tlast, done, en_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_pwm_linear();
    for (int i = 0; i < NC; i++) mem[i] = 32'(i);
    run_transfer(2'b00, 2'b00, 0, -1, -1, 2051);
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_width got done=%b want 0", done);
    end
  endtask

  task automatic test_ntt_q1();
    for (int i = 0; i < NC; i++) mem[i] = 32'(i);
    mem[0] = 32'd0; mem[1] = 32'd67125248; mem[2] = 32'd67125249; mem[3] = 32'd134250496;
    run_transfer(2'b01, 2'b00, 0, -1, -1, 2051);
    tests++;
    if (obs_beat[0] !== {32'd67125248, 32'd0} || obs_beat[1] !== {32'hFFFFFFFF, 32'hFBFFC000}) begin
      fails++;
      $display("FAIL ntt_q1_beats got %h %h want %h %h", obs_beat[0], obs_beat[1],
               {32'd67125248, 32'd0}, {32'hFFFFFFFF, 32'hFBFFC000});
    end
  endtask

  task automatic test_ntt_q2();
    for (int i = 0; i < NC; i++) mem[i] = $urandom_range(0, 536903680);
    mem[0] = 32'd536903680; mem[1] = 32'd268451840;
    run_transfer(2'b10, 2'b11, 0, -1, -1, 2051);
    tests++;
    if (obs_beat[0] !== {32'd268451840, 32'hFFFFFFFF}) begin
      fails++;
      $display("FAIL ntt_q2_beat0 got %h want %h", obs_beat[0], {32'd268451840, 32'hFFFFFFFF});
    end
  endtask

  task automatic test_random_ready();
    for (int i = 0; i < NC; i++) mem[i] = $urandom_range(0, 536903680);
    run_transfer(2'b10, 2'b01, 1, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NC; i++) mem[i] = $urandom();
    run_transfer(2'b00, 2'b00, 0, 100, -1, 2051);
    for (int i = 0; i < NC; i++) mem[i] = $urandom_range(0, 134250496);
    run_transfer(2'b01, 2'b00, 0, -1, -1, 2051);
    check_quiet("idle_after_b2b", 8);
  endtask

  task automatic test_abort();
    for (int i = 0; i < NC; i++) mem[i] = $urandom_range(0, 134250496);
    run_transfer(2'b10, 2'b00, 0, -1, 100, -1);
    check_quiet("no_done_after_abort", 10);
    run_transfer(2'b10, 2'b00, 0, -1, -1, 2051);
  endtask

  initial begin
    test_reset();
    test_pwm_linear();
    test_ntt_q1();
    test_ntt_q2();
    test_random_ready();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
